// File: rtl/dma_regs.sv
// CPU-facing DMA register bank: operand/control registers, start handshake to the engine,
// CPU halt while a transfer runs and system bus hand-over to the engine.
module dma_regs (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        reg_cs,
   input  logic        reg_we,
   input  logic [2:0]  reg_addr,
   input  logic [7:0]  reg_din,
   output logic [7:0]  reg_dout,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_write,
   output logic        cpu_rdy,
   output logic [7:0]  ctrl,
   output logic [15:0] src_addr,
   output logic [15:0] dst_addr,
   output logic [7:0]  length,
   input  logic        dma_busy,
   input  logic [15:0] dma_addr,
   input  logic [7:0]  dma_dout,
   input  logic        dma_write,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_dout,
   output logic        bus_write
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StArm    = 2'd1,
      StRun    = 2'd2,
      StFinish = 2'd3
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] src_lo_q, src_hi_q, dst_lo_q, dst_hi_q, len_q, ctrl_q;
   logic       clr_start;
   logic       idle;
   logic       wr_en;

   assign idle  = (state_q == StIdle);
   assign wr_en = reg_cs & reg_we;

   always_comb begin
      state_d   = state_q;
      clr_start = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (dma_busy) begin
               state_d = StRun;
            end else if (wr_en && (reg_addr == 3'd5) && reg_din[7]) begin
               state_d = StArm;
            end
         end
         StArm: begin
            if (dma_busy) begin
               state_d   = StRun;
               clr_start = 1'b1;
            end
         end
         StRun: begin
            if (!dma_busy) begin
               state_d = StFinish;
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         src_lo_q <= 8'h00;
         src_hi_q <= 8'h00;
         dst_lo_q <= 8'h00;
         dst_hi_q <= 8'h00;
         len_q    <= 8'h00;
         ctrl_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         if (idle && wr_en) begin
            case (reg_addr)
               3'd0: src_lo_q <= reg_din;
               3'd1: src_hi_q <= reg_din;
               3'd2: dst_lo_q <= reg_din;
               3'd3: dst_hi_q <= reg_din;
               3'd4: len_q    <= reg_din;
               // An engine already busy takes us straight to RUN, so never leave start stuck high
               3'd5: ctrl_q   <= {reg_din[7] & ~dma_busy, reg_din[6:0]};
               default: ;
            endcase
         end
         if (clr_start) begin
            ctrl_q[7] <= 1'b0;
         end
      end
   end

   always_comb begin
      reg_dout = 8'h00;
      if (reg_cs && !reg_we) begin
         case (reg_addr)
            3'd0:    reg_dout = src_lo_q;
            3'd1:    reg_dout = src_hi_q;
            3'd2:    reg_dout = dst_lo_q;
            3'd3:    reg_dout = dst_hi_q;
            3'd4:    reg_dout = len_q;
            3'd5:    reg_dout = {~idle, ctrl_q[6:0]};
            default: reg_dout = 8'h00;
         endcase
      end
   end

   assign cpu_rdy  = idle;
   assign ctrl     = ctrl_q;
   assign src_addr = {src_hi_q, src_lo_q};
   assign dst_addr = {dst_hi_q, dst_lo_q};
   assign length   = len_q;

   always_comb begin
      if (state_q == StRun) begin
         bus_addr  = dma_addr;
         bus_dout  = dma_dout;
         bus_write = dma_write;
      end else begin
         bus_addr  = cpu_addr;
         bus_dout  = cpu_dout;
         bus_write = cpu_write;
      end
   end

endmodule

// File: tb/tb_dma_regs.sv
// Directed bench for dma_regs: a hand-timed engine model drives dma_busy around each start.
module tb_dma_regs;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        reg_cs, reg_we;
   logic [2:0]  reg_addr;
   logic [7:0]  reg_din, reg_dout;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dout;
   logic        cpu_write, cpu_rdy;
   logic [7:0]  ctrl, length;
   logic [15:0] src_addr, dst_addr;
   logic        dma_busy;
   logic [15:0] dma_addr;
   logic [7:0]  dma_dout;
   logic        dma_write;
   logic [15:0] bus_addr;
   logic [7:0]  bus_dout;
   logic        bus_write;

   int errors = 0;
   int checks = 0;

   dma_regs dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .reg_cs    (reg_cs),
      .reg_we    (reg_we),
      .reg_addr  (reg_addr),
      .reg_din   (reg_din),
      .reg_dout  (reg_dout),
      .cpu_addr  (cpu_addr),
      .cpu_dout  (cpu_dout),
      .cpu_write (cpu_write),
      .cpu_rdy   (cpu_rdy),
      .ctrl      (ctrl),
      .src_addr  (src_addr),
      .dst_addr  (dst_addr),
      .length    (length),
      .dma_busy  (dma_busy),
      .dma_addr  (dma_addr),
      .dma_dout  (dma_dout),
      .dma_write (dma_write),
      .bus_addr  (bus_addr),
      .bus_dout  (bus_dout),
      .bus_write (bus_write)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      reg_cs = 1'b1; reg_we = 1'b1; reg_addr = a; reg_din = d;
      step();
      reg_cs = 1'b0; reg_we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [7:0] d);
      reg_cs = 1'b1; reg_we = 1'b0; reg_addr = a;
      #1 d = reg_dout;
      reg_cs = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #2;
      checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h want 00", ctrl); end
      checks++; if (src_addr !== 16'h0000) begin errors++; $display("FAIL reset_src: got %h want 0000", src_addr); end
      checks++; if (dst_addr !== 16'h0000) begin errors++; $display("FAIL reset_dst: got %h want 0000", dst_addr); end
      checks++; if (length !== 8'h00) begin errors++; $display("FAIL reset_len: got %h want 00", length); end
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", cpu_rdy); end
      checks++; if (bus_addr !== 16'h1111) begin errors++; $display("FAIL reset_bus: got %h want 1111", bus_addr); end
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_program();
      logic [7:0] d;
      wr(3'd0, 8'h34); wr(3'd1, 8'h12); wr(3'd2, 8'h00); wr(3'd3, 8'h40); wr(3'd4, 8'h02);
      checks++; if (src_addr !== 16'h1234) begin errors++; $display("FAIL prog_src: got %h want 1234", src_addr); end
      checks++; if (dst_addr !== 16'h4000) begin errors++; $display("FAIL prog_dst: got %h want 4000", dst_addr); end
      checks++; if (length !== 8'h02) begin errors++; $display("FAIL prog_len: got %h want 02", length); end
      rd(3'd1, d);
      checks++; if (d !== 8'h12) begin errors++; $display("FAIL rd_src_hi: got %h want 12", d); end
      rd(3'd3, d);
      checks++; if (d !== 8'h40) begin errors++; $display("FAIL rd_dst_hi: got %h want 40", d); end
      rd(3'd4, d);
      checks++; if (d !== 8'h02) begin errors++; $display("FAIL rd_len: got %h want 02", d); end
   endtask

   task automatic test_transfer();
      logic [7:0] d;
      wr(3'd5, 8'h80);  // edge T
      checks++; if (ctrl !== 8'h80) begin errors++; $display("FAIL start_ctrl: got %h want 80", ctrl); end
      checks++; if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL start_rdy: got %b want 0", cpu_rdy); end
      dma_busy = 1'b1;
      rd(3'd5, d);
      checks++; if (d !== 8'h80) begin errors++; $display("FAIL arm_rd5: got %h want 80", d); end
      step();  // T+1: RUN
      checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL run_ctrl: got %h want 00", ctrl); end
      dma_addr = 16'h4005; dma_write = 1'b1; dma_dout = 8'h5A;
      cpu_addr = 16'hFFFF; cpu_write = 1'b0; cpu_dout = 8'hC3;
      #1;
      checks++; if (bus_addr !== 16'h4005) begin errors++; $display("FAIL run_bus_addr: got %h want 4005", bus_addr); end
      checks++; if (bus_write !== 1'b1) begin errors++; $display("FAIL run_bus_wr: got %b want 1", bus_write); end
      checks++; if (bus_dout !== 8'h5A) begin errors++; $display("FAIL run_bus_dout: got %h want 5a", bus_dout); end
      rd(3'd5, d);
      checks++; if (d !== 8'h80) begin errors++; $display("FAIL run_rd5: got %h want 80", d); end
      wr(3'd0, 8'hAA);  // T+2, ignored in RUN
      for (int i = 0; i < 8; i++) begin
         step();  // T+3 .. T+10
         checks++; if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL run_halt[%0d]: got %b want 0", i, cpu_rdy); end
      end
      dma_busy = 1'b0;
      step();  // FINISH
      checks++; if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL fin_rdy: got %b want 0", cpu_rdy); end
      checks++; if (bus_addr !== 16'hFFFF) begin errors++; $display("FAIL fin_bus: got %h want ffff", bus_addr); end
      checks++; if (bus_write !== 1'b0) begin errors++; $display("FAIL fin_bus_wr: got %b want 0", bus_write); end
      step();  // IDLE
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL end_rdy: got %b want 1", cpu_rdy); end
      rd(3'd5, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL end_rd5: got %h want 00", d); end
      rd(3'd0, d);
      checks++; if (d !== 8'h34) begin errors++; $display("FAIL run_wr_ignored: got %h want 34", d); end
   endtask

   task automatic test_arm_delay();
      logic [7:0] d;
      wr(3'd5, 8'h80);  // edge T
      for (int i = 0; i < 5; i++) begin
         checks++; if (ctrl[7] !== 1'b1) begin errors++; $display("FAIL arm_ctrl7[%0d]: got %b want 1", i, ctrl[7]); end
         checks++; if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL arm_rdy[%0d]: got %b want 0", i, cpu_rdy); end
         checks++; if (bus_addr !== 16'hFFFF) begin errors++; $display("FAIL arm_bus[%0d]: got %h want ffff", i, bus_addr); end
         if (i == 2) begin
            reg_cs = 1'b1; reg_we = 1'b1; reg_addr = 3'd0; reg_din = 8'hAA;
         end
         if (i < 4) begin
            step();
            reg_cs = 1'b0; reg_we = 1'b0;
         end
      end
      dma_busy = 1'b1;
      step();  // T+5: RUN
      checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL late_run_ctrl: got %h want 00", ctrl); end
      checks++; if (bus_addr !== 16'h4005) begin errors++; $display("FAIL late_run_bus: got %h want 4005", bus_addr); end
      dma_busy = 1'b0;
      step();
      step();
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL late_end_rdy: got %b want 1", cpu_rdy); end
      rd(3'd0, d);
      checks++; if (d !== 8'h34) begin errors++; $display("FAIL arm_wr_ignored: got %h want 34", d); end
   endtask

   task automatic test_ctrl_no_start();
      logic [7:0] d;
      wr(3'd5, 8'h05);
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL nostart_rdy0: got %b want 1", cpu_rdy); end
      checks++; if (ctrl !== 8'h05) begin errors++; $display("FAIL nostart_ctrl: got %h want 05", ctrl); end
      step();
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL nostart_rdy1: got %b want 1", cpu_rdy); end
      rd(3'd5, d);
      checks++; if (d !== 8'h05) begin errors++; $display("FAIL nostart_rd5: got %h want 05", d); end
   endtask

   task automatic test_reset_mid_run();
      wr(3'd5, 8'h80);
      dma_busy = 1'b1;
      step();  // RUN
      checks++; if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL mid_run_rdy: got %b want 0", cpu_rdy); end
      reset_n = 1'b0;
      #1;
      checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL mid_rst_ctrl: got %h want 00", ctrl); end
      checks++; if (src_addr !== 16'h0000) begin errors++; $display("FAIL mid_rst_src: got %h want 0000", src_addr); end
      checks++; if (dst_addr !== 16'h0000) begin errors++; $display("FAIL mid_rst_dst: got %h want 0000", dst_addr); end
      checks++; if (length !== 8'h00) begin errors++; $display("FAIL mid_rst_len: got %h want 00", length); end
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL mid_rst_rdy: got %b want 1", cpu_rdy); end
      checks++; if (bus_addr !== 16'hFFFF) begin errors++; $display("FAIL mid_rst_bus: got %h want ffff", bus_addr); end
      step();  // busy cycle 1, still in reset
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL rst_hold_rdy: got %b want 1", cpu_rdy); end
      reset_n = 1'b1;
      step();  // busy cycle 2: RUN re-entered
      checks++; if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL post_rst_rdy: got %b want 0", cpu_rdy); end
      checks++; if (bus_addr !== 16'h4005) begin errors++; $display("FAIL post_rst_bus: got %h want 4005", bus_addr); end
      step();
      step();  // busy cycle 4
      dma_busy = 1'b0;
      step();  // FINISH
      checks++; if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL post_rst_fin: got %b want 0", cpu_rdy); end
      step();  // IDLE
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL post_rst_idle: got %b want 1", cpu_rdy); end
   endtask

   task automatic test_unused_reads();
      logic [7:0] d;
      wr(3'd0, 8'h11);
      wr(3'd6, 8'hFF);
      wr(3'd7, 8'hFF);
      checks++; if (src_addr !== 16'h0011) begin errors++; $display("FAIL unused_wr: got %h want 0011", src_addr); end
      rd(3'd6, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL rd6: got %h want 00", d); end
      rd(3'd7, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL rd7: got %h want 00", d); end
      rd(3'd0, d);
      checks++; if (d !== 8'h11) begin errors++; $display("FAIL rd0: got %h want 11", d); end
      reg_cs = 1'b0; reg_we = 1'b0; reg_addr = 3'd0;
      #1;
      checks++; if (reg_dout !== 8'h00) begin errors++; $display("FAIL rd_nocs: got %h want 00", reg_dout); end
   endtask

   initial begin
      reset_n   = 1'b1;
      reg_cs    = 1'b0;
      reg_we    = 1'b0;
      reg_addr  = 3'd0;
      reg_din   = 8'h00;
      cpu_addr  = 16'h1111;
      cpu_dout  = 8'h00;
      cpu_write = 1'b0;
      dma_busy  = 1'b0;
      dma_addr  = 16'h0000;
      dma_dout  = 8'h00;
      dma_write = 1'b0;
      #1;
      test_reset();
      test_program();
      test_transfer();
      test_arm_delay();
      test_ctrl_no_start();
      test_reset_mid_run();
      test_unused_reads();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dma_regs.md
# dma_regs

CPU-facing register bank and bus arbiter for the DMA engine. Holds the source, destination, length and control registers the CPU programs through the I/O window, and converts a start write into the level-held `ctrl[7]` the engine edge-detects. Halts the CPU via `cpu_rdy` for the whole transfer and hands the system bus to the engine while it runs. Sits between the CPU/I/O decoder upstream and the DMA engine downstream.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock, same clock as the DMA engine
- `reset_n`  in  1  asynchronous, active-low reset
- `reg_cs`  in  1  CPU access to DMA register window this cycle
- `reg_we`  in  1  1 = write, 0 = read (qualified by `reg_cs`)
- `reg_addr`  in  3  register offset: 0 src lo, 1 src hi, 2 dst lo, 3 dst hi, 4 length, 5 ctrl, 6–7 unused
- `reg_din`  in  8  CPU write data
- `reg_dout`  out  8  CPU read data (combinational)
- `cpu_addr`  in  16  CPU bus address
- `cpu_dout`  in  8  CPU bus write data
- `cpu_write`  in  1  CPU bus write strobe
- `cpu_rdy`  out  1  0 halts CPU
- `ctrl`  out  8  to DMA engine
- `src_addr`  out  16  to DMA engine
- `dst_addr`  out  16  to DMA engine
- `length`  out  8  to DMA engine
- `dma_busy`  in  1  from DMA engine
- `dma_addr`  in  16  from DMA engine
- `dma_dout`  in  8  from DMA engine
- `dma_write`  in  1  from DMA engine
- `bus_addr`  out  16  arbitrated system bus address
- `bus_dout`  out  8  arbitrated write data
- `bus_write`  out  1  arbitrated write strobe

## Operation
- States: IDLE, ARM, RUN, FINISH (2-bit).
- IDLE: a `reg_cs & reg_we` write to offset 5 with `reg_din[7]=1` loads `ctrl <= reg_din` and moves to ARM. With `reg_din[7]=0`, it only loads `ctrl`.
- IDLE with `dma_busy=1` (engine still running after a reset): go directly to RUN.
- ARM: `ctrl[7]` is held at 1. When `dma_busy` is sampled at 1, go to RUN and clear `ctrl[7]` on the same edge. ARM has no timeout.
- RUN: stays in RUN while `dma_busy=1`. When `dma_busy` is sampled at 0, go to FINISH.
- FINISH: lasts one cycle, then returns to IDLE.
- `cpu_rdy` = (state == IDLE).
- Bus ownership:
  - In RUN: `bus_addr/bus_dout/bus_write` = `dma_addr/dma_dout/dma_write`.
  - In all other states: they equal `cpu_addr/cpu_dout/cpu_write`.
- Register writes:
  - Offsets 0–4 are written only in IDLE. In ARM, RUN or FINISH they are ignored, which keeps the engine's operands stable.
  - A write to offset 5 outside IDLE is ignored.
  - Writes to offsets 6–7 are ignored.
- Reads (`reg_cs & ~reg_we`):
  - Offsets 0–4 return the stored byte.
  - Offset 5 returns `{state!=IDLE, ctrl[6:0]}`.
  - Offsets 6–7 return 0.
  - With `reg_cs=0`, `reg_dout=0`.
- Address assembly: `src_addr = {src_hi, src_lo}`, `dst_addr = {dst_hi, dst_lo}`. No arithmetic is done here; the byte count implied by `length` is the engine's concern.

## Timing
- Reset (asynchronous, while `reset_n=0`):
  - state IDLE
  - all registers 0, so `ctrl=0`, `src_addr=0`, `dst_addr=0`, `length=0`
  - `cpu_rdy=1`
  - bus outputs follow the CPU
- Reset mid-transfer: registers are cleared. If `dma_busy` is still 1 after release, the block enters RUN on the first edge, so `cpu_rdy` drops one cycle after release and the engine keeps the bus.
- Start write sampled at edge T:
  - `ctrl[7]=1` and `cpu_rdy=0` from T.
  - The engine raises `dma_busy` after T+1.
  - ARM→RUN at the edge where busy is first sampled high; `ctrl[7]` falls there, giving a minimum ARM of 1 cycle.
- End of transfer:
  - `dma_busy` falls after edge E; RUN→FINISH at E+1; IDLE at E+2.
  - `cpu_rdy` returns high 2 cycles after the busy falling edge.
- Bus mux is combinational on state; the switch happens on the same edge as the state change.
- A register write and a start cannot coincide with RUN, since both are gated to IDLE.

## Test plan
- Program src=0x1234, dst=0x4000, length=0x02, then ctrl=0x80, with a model engine (busy 1 cycle after ctrl[7] rises, 10 cycles long) -> outputs show 0x1234/0x4000/0x02; ctrl[7] high exactly 1 cycle; cpu_rdy low from start edge until 2 cycles after busy falls; offset 5 reads 0x80 during the halt and 0x00 after.
- During RUN, drive dma_addr=0x4005, dma_write=1 and cpu_addr=0xFFFF -> bus_addr=0x4005, bus_write=1; in FINISH, bus_addr=0xFFFF.
- Write src lo=0xAA while in ARM and while in RUN -> readback of offset 0 stays at the old value; write ctrl=0x05 in IDLE -> no start, cpu_rdy stays 1, offset 5 reads 0x05.
- Model engine delays busy by 5 cycles -> state stays ARM and ctrl[7] stays 1 for all 5; RUN entered on the edge busy is first seen.
- Assert reset_n=0 mid-RUN while the model keeps busy=1 for 4 more cycles -> all registers 0 during reset, cpu_rdy=1; after release, RUN is entered next edge and cpu_rdy returns 1 two cycles after busy falls.
- Read offsets 6 and 7, and read with reg_cs=0 -> reg_dout=0x00.
